// File: rtl/nand_cmd_sequencer.sv
// Page read / page program command sequencer feeding nand_interface control codes.
// All outputs decode from registered state; io_out and rd_data are registered.
module nand_cmd_sequencer #(
  parameter int         ADDR_CYCLES  = 3,
  parameter int         LEN_W        = 12,
  parameter logic [7:0] PROG_CONFIRM = 8'h10,
  parameter int         TIMEOUT      = 4095
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     op_prog,
  input  logic [7:0]               cmd,
  input  logic [8*ADDR_CYCLES-1:0] addr,
  input  logic [LEN_W-1:0]         len,
  input  logic [7:0]               wr_data,
  output logic                     wr_req,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  output logic [7:0]               io_out,
  output logic                     io_oe,
  input  logic [7:0]               io_in,
  input  logic                     rb,
  output logic [2:0]               h_cntrl,
  output logic                     e_d,
  output logic                     h_rd_wr,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);
  localparam int         AW        = 8 * ADDR_CYCLES;
  localparam int         TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [2:0] ACNT_LAST = 3'(ADDR_CYCLES - 1);

  localparam logic [2:0] C_CLE = 3'b000;
  localparam logic [2:0] C_RE  = 3'b001;
  localparam logic [2:0] C_WE  = 3'b010;
  localparam logic [2:0] C_ALE = 3'b011;
  localparam logic [2:0] C_WP  = 3'b101;
  localparam logic [2:0] C_CE  = 3'b110;
  localparam logic [2:0] C_RDY = 3'b111;

  typedef enum logic [4:0] {
    S_IDLE, S_CE_ON, S_WP_OFF, S_CMD_SET, S_CMD_WE, S_ADDR_SET, S_ADDR_WE,
    S_ALE_OFF, S_DSET, S_DWE, S_CONF_SET, S_CONF_WE, S_WAIT_RDY, S_WP_ON,
    S_RD, S_CAP, S_CE_OFF
  } state_e;

  state_e          state_q, state_d;
  logic            prog_q, prog_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [AW-1:0]   addr_sh_q, addr_sh_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [2:0]      acnt_q, acnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [7:0]      io_out_q, io_out_d;
  logic [7:0]      rd_data_q, rd_data_d;
  logic            err_q, err_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      prog_q    <= 1'b0;
      cmd_q     <= '0;
      addr_sh_q <= '0;
      len_q     <= '0;
      acnt_q    <= '0;
      tmo_q     <= '0;
      io_out_q  <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prog_q    <= prog_d;
      cmd_q     <= cmd_d;
      addr_sh_q <= addr_sh_d;
      len_q     <= len_d;
      acnt_q    <= acnt_d;
      tmo_q     <= tmo_d;
      io_out_q  <= io_out_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    prog_d    = prog_q;
    cmd_d     = cmd_q;
    addr_sh_d = addr_sh_q;
    len_d     = len_q;
    acnt_d    = acnt_q;
    tmo_d     = '0;
    io_out_d  = io_out_q;
    rd_data_d = rd_data_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d   = S_CE_ON;
        prog_d    = op_prog;
        cmd_d     = cmd;
        addr_sh_d = addr;
        len_d     = len;
        acnt_d    = '0;
        err_d     = 1'b0;
      end
      S_CE_ON:    state_d = prog_q ? S_WP_OFF : S_CMD_SET;
      S_WP_OFF:   state_d = S_CMD_SET;
      S_CMD_SET:  state_d = S_CMD_WE;
      S_CMD_WE:   state_d = S_ADDR_SET;
      S_ADDR_SET: begin
        state_d   = S_ADDR_WE;
        addr_sh_d = addr_sh_q >> 8;
      end
      S_ADDR_WE: begin
        if (acnt_q == ACNT_LAST) state_d = S_ALE_OFF;
        else begin
          acnt_d  = acnt_q + 3'd1;
          state_d = S_ADDR_SET;
        end
      end
      S_ALE_OFF: begin
        if (!prog_q)            state_d = S_WAIT_RDY;
        else if (len_q == '0)   state_d = S_CONF_SET;
        else                    state_d = S_DSET;
      end
      S_DSET: state_d = S_DWE;
      S_DWE: begin
        len_d   = len_q - LEN_W'(1);
        state_d = (len_q == LEN_W'(1)) ? S_CONF_SET : S_DSET;
      end
      S_CONF_SET: state_d = S_CONF_WE;
      S_CONF_WE:  state_d = S_WAIT_RDY;
      S_WAIT_RDY: begin
        tmo_d = tmo_q + TW'(1);
        if (rb) begin
          if (prog_q)           state_d = S_WP_ON;
          else if (len_q == '0) state_d = S_CE_OFF;
          else                  state_d = S_RD;
        end else if (tmo_q == TMO_LAST) begin
          // Timeout abandons any remaining data phase.
          err_d   = 1'b1;
          state_d = prog_q ? S_WP_ON : S_CE_OFF;
        end
      end
      S_WP_ON: state_d = S_CE_OFF;
      S_RD: begin
        state_d   = S_CAP;
        rd_data_d = io_in;
      end
      S_CAP: begin
        len_d   = len_q - LEN_W'(1);
        state_d = (len_q == LEN_W'(1)) ? S_CE_OFF : S_RD;
      end
      S_CE_OFF: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Load the I/O byte on entry so it is already stable when the SET state begins.
    case (state_d)
      S_CMD_SET:  io_out_d = cmd_q;
      S_ADDR_SET: io_out_d = addr_sh_q[7:0];
      S_DSET:     io_out_d = wr_data;
      S_CONF_SET: io_out_d = PROG_CONFIRM;
      default:    io_out_d = io_out_q;
    endcase
  end

  always_comb begin
    h_cntrl  = C_CE;
    e_d      = 1'b0;
    h_rd_wr  = 1'b0;
    io_oe    = 1'b0;
    wr_req   = 1'b0;
    rd_valid = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_IDLE:     ;
      S_CE_ON:    e_d = 1'b1;
      S_WP_OFF:   h_cntrl = C_WP;
      S_CMD_SET:  begin h_cntrl = C_CLE; e_d = 1'b1; io_oe = 1'b1; end
      S_CMD_WE:   begin h_cntrl = C_WE;  e_d = 1'b1; io_oe = 1'b1; end
      S_ADDR_SET: begin h_cntrl = C_ALE; e_d = 1'b1; io_oe = 1'b1; end
      S_ADDR_WE:  begin h_cntrl = C_WE;  e_d = 1'b1; io_oe = 1'b1; end
      S_ALE_OFF:  h_cntrl = C_ALE;
      S_DSET:     begin e_d = 1'b1; io_oe = 1'b1; wr_req = 1'b1; end
      S_DWE:      begin h_cntrl = C_WE;  e_d = 1'b1; io_oe = 1'b1; end
      S_CONF_SET: begin h_cntrl = C_CLE; e_d = 1'b1; io_oe = 1'b1; end
      S_CONF_WE:  begin h_cntrl = C_WE;  e_d = 1'b1; io_oe = 1'b1; end
      S_WAIT_RDY: h_cntrl = C_RDY;
      S_WP_ON:    begin h_cntrl = C_WP; e_d = 1'b1; end
      S_RD:       begin h_cntrl = C_RE; e_d = 1'b1; h_rd_wr = 1'b1; end
      S_CAP:      begin e_d = 1'b1; rd_valid = 1'b1; end
      S_CE_OFF:   done = 1'b1;
      default:    ;
    endcase
  end

  assign busy    = (state_q != S_IDLE);
  assign io_out  = io_out_q;
  assign rd_data = rd_data_q;
  assign err     = err_q;

endmodule

// File: tb/tb_nand_cmd_sequencer.sv
// Directed bench for nand_cmd_sequencer: reset, read, program, timeout, len=0 and start-ignore cases.
module tb_nand_cmd_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op_prog;
  logic [7:0]  cmd;
  logic [23:0] addr;
  logic [11:0] len;
  logic [7:0]  wr_data;
  logic        wr_req;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [7:0]  io_out;
  logic        io_oe;
  logic [7:0]  io_in;
  logic        rb;
  logic [2:0]  h_cntrl;
  logic        e_d;
  logic        h_rd_wr;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [2:0] rcodes [16] = '{3'b110, 3'b000, 3'b010, 3'b011, 3'b010, 3'b011, 3'b010, 3'b011,
                              3'b010, 3'b011, 3'b111, 3'b001, 3'b110, 3'b001, 3'b110, 3'b110};
  logic [2:0] pcodes [22] = '{3'b110, 3'b101, 3'b000, 3'b010, 3'b011, 3'b010, 3'b011, 3'b010,
                              3'b011, 3'b010, 3'b011, 3'b110, 3'b010, 3'b110, 3'b010, 3'b110,
                              3'b010, 3'b000, 3'b010, 3'b111, 3'b101, 3'b110};

  nand_cmd_sequencer #(
    .ADDR_CYCLES(3), .LEN_W(12), .PROG_CONFIRM(8'h10), .TIMEOUT(15)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .op_prog(op_prog), .cmd(cmd),
    .addr(addr), .len(len), .wr_data(wr_data), .wr_req(wr_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .io_out(io_out), .io_oe(io_oe),
    .io_in(io_in), .rb(rb), .h_cntrl(h_cntrl), .e_d(e_d), .h_rd_wr(h_rd_wr),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Read of two bytes with stray start pulses while busy and in the done cycle.
  task automatic read_seq(input string nm);
    int nrv;
    nrv = 0;
    op_prog = 1'b0; cmd = 8'h00; addr = 24'h123456; len = 12'd2; rb = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      start = (c == 5 || c == 16);
      chk($sformatf("%s code c%0d", nm, c), h_cntrl, rcodes[c-1]);
      chk($sformatf("%s done c%0d", nm, c), done, (c == 16));
      chk($sformatf("%s busy c%0d", nm, c), busy, 1'b1);
      if (rd_valid) nrv++;
      if (c == 4) chk({nm, " addr0"}, io_out, 8'h56);
      if (c == 6) chk({nm, " addr1"}, io_out, 8'h34);
      if (c == 8) chk({nm, " addr2"}, io_out, 8'h12);
      if (c == 5) chk({nm, " addr_we oe"}, io_oe, 1'b1);
      if (c == 12) begin
        chk({nm, " rd h_rd_wr"}, h_rd_wr, 1'b1);
        chk({nm, " rd io_oe"}, io_oe, 1'b0);
        io_in = 8'hA5;
      end
      if (c == 14) io_in = 8'h5A;
      if (c == 13) begin
        chk({nm, " cap0 valid"}, rd_valid, 1'b1);
        chk({nm, " cap0 data"}, rd_data, 8'hA5);
      end
      if (c == 15) begin
        chk({nm, " cap1 valid"}, rd_valid, 1'b1);
        chk({nm, " cap1 data"}, rd_data, 8'h5A);
      end
    end
    tick();
    start = 1'b0;
    chk({nm, " idle busy"}, busy, 1'b0);
    chk({nm, " idle code"}, h_cntrl, 3'b110);
    chk({nm, " idle e_d"}, e_d, 1'b0);
    chk({nm, " rd_valid count"}, nrv, 2);
    tick();
    chk({nm, " still idle"}, busy, 1'b0);
  endtask

  initial begin
    int nw;
    int nrv;
    reset = 1'b0; start = 1'b0; op_prog = 1'b0; cmd = '0; addr = '0; len = '0;
    wr_data = '0; io_in = '0; rb = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst code", h_cntrl, 3'b110);
    chk("rst e_d", e_d, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst io_oe", io_oe, 1'b0);
    chk("rst io_out", io_out, 8'h00);
    chk("rst rd_data", rd_data, 8'h00);
    chk("rst flags", {done, err, rd_valid, wr_req, h_rd_wr}, 5'b0);
    reset = 1'b1;
    tick();
    chk("post-rst busy", busy, 1'b0);

    read_seq("read");

    // Program of three bytes
    op_prog = 1'b1; cmd = 8'h80; addr = 24'hABCDEF; len = 12'd3; rb = 1'b1;
    wr_data = 8'h11;
    start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      tick();
      start = 1'b0;
      wr_data = (c < 13) ? 8'h11 : (c < 15) ? 8'h22 : 8'h33;
      chk($sformatf("prog code c%0d", c), h_cntrl, pcodes[c-1]);
      chk($sformatf("prog done c%0d", c), done, (c == 22));
      chk($sformatf("prog wr_req c%0d", c), wr_req, (c == 12 || c == 14 || c == 16));
      if (c == 2)  chk("prog wp_off e_d", e_d, 1'b0);
      if (c == 3)  chk("prog cmd byte", io_out, 8'h80);
      if (c == 13) chk("prog dwe0", io_out, 8'h11);
      if (c == 15) chk("prog dwe1", io_out, 8'h22);
      if (c == 17) chk("prog dwe2", io_out, 8'h33);
      if (c == 17) chk("prog dwe oe", io_oe, 1'b1);
      if (c == 19) chk("prog confirm", io_out, 8'h10);
      if (c == 21) chk("prog wp_on e_d", e_d, 1'b1);
    end
    tick();
    chk("prog idle busy", busy, 1'b0);
    chk("prog err", err, 1'b0);

    // Program with ready never asserting
    op_prog = 1'b1; cmd = 8'h80; len = 12'd1; rb = 1'b0; wr_data = 8'h77;
    start = 1'b1;
    nw = 0;
    for (int c = 1; c <= 32; c++) begin
      tick();
      start = 1'b0;
      if (h_cntrl == 3'b111) nw++;
      if (c == 30) chk("tmo last wait err", err, 1'b0);
      if (c == 31) begin
        chk("tmo wp_on code", h_cntrl, 3'b101);
        chk("tmo wp_on e_d", e_d, 1'b1);
        chk("tmo err set", err, 1'b1);
      end
      if (c == 32) begin
        chk("tmo ce_off code", h_cntrl, 3'b110);
        chk("tmo done", done, 1'b1);
        chk("tmo err hold", err, 1'b1);
      end
    end
    chk("tmo wait cycles", nw, 15);
    repeat (3) tick();
    chk("tmo idle busy", busy, 1'b0);
    chk("tmo err sticky", err, 1'b1);

    // Read with no data phase; also clears err
    op_prog = 1'b0; cmd = 8'h00; len = 12'd0; rb = 1'b1;
    start = 1'b1;
    nrv = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      start = 1'b0;
      if (rd_valid) nrv++;
      if (c == 1)  chk("len0 err cleared", err, 1'b0);
      if (c == 11) chk("len0 wait code", h_cntrl, 3'b111);
      chk($sformatf("len0 done c%0d", c), done, (c == 12));
    end
    chk("len0 ce_off code", h_cntrl, 3'b110);
    chk("len0 rd_valid count", nrv, 0);
    tick();
    chk("len0 idle busy", busy, 1'b0);

    // Asynchronous reset in the middle of an address strobe
    op_prog = 1'b0; cmd = 8'h00; addr = 24'h123456; len = 12'd2; rb = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
    end
    chk("mid addr_we code", h_cntrl, 3'b010);
    reset = 1'b0;
    #1;
    chk("async rst code", h_cntrl, 3'b110);
    chk("async rst e_d", e_d, 1'b0);
    chk("async rst busy", busy, 1'b0);
    chk("async rst io_oe", io_oe, 1'b0);
    chk("async rst io_out", io_out, 8'h00);
    #1;
    reset = 1'b1;
    tick();
    tick();
    chk("no resume busy", busy, 1'b0);
    chk("no resume code", h_cntrl, 3'b110);

    read_seq("reread");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
